// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA bus master: FSM encoding, default widths
// and the ALU slave register offsets that DMA blocks usually target.
package dmac_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 32;
  localparam int DEF_LW = 8;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_REQ   = 3'd1;
  localparam logic [2:0] ENC_RD    = 3'd2;
  localparam logic [2:0] ENC_LATCH = 3'd3;
  localparam logic [2:0] ENC_WR    = 3'd4;
  localparam logic [2:0] ENC_DONE  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_REQ   = ENC_REQ,
    ST_RD    = ENC_RD,
    ST_LATCH = ENC_LATCH,
    ST_WR    = ENC_WR,
    ST_DONE  = ENC_DONE
  } state_t;

  // ALU slave offsets: fixed-address targets for streaming in / draining out
  localparam logic [15:0] ALU_OP_START  = 16'h0000;
  localparam logic [15:0] ALU_INSTR     = 16'h0003;
  localparam logic [15:0] ALU_RESULT    = 16'h0004;
  localparam logic [15:0] ALU_REGF_BASE = 16'h0010;
  localparam logic [15:0] ALU_REGF_LAST = 16'h001F;

endpackage

// File: rtl/dmac_addr_cnt.sv
// Loadable address register that optionally advances by one word per step.
// Wraps modulo 2^AW.
module dmac_addr_cnt #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          step,
  input  logic          inc,
  output logic [AW-1:0] q
);

  logic [AW-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= load_val;
    end else if (step && inc) begin
      q_reg <= q_reg + AW'(1);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/dmac_master.sv
// DMA bus master: copies a block of words, one bus read then one bus write
// per word, with independently fixed or incrementing source/destination.
module dmac_master
  import dmac_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int LW = DEF_LW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          op_start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] data_size,
  input  logic          src_inc,
  input  logic          dst_inc,
  input  logic          int_en,
  input  logic          opdone_clear,
  output logic          m_req,
  input  logic          m_grant,
  output logic          m_sel,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_dout,
  input  logic [DW-1:0] m_din,
  output logic          busy,
  output logic          op_done,
  output logic          m_interrupt
);

  state_t        state_reg, state_next;
  logic          op_start_q_reg;
  logic          start;
  logic [LW-1:0] cnt_reg;
  logic [DW-1:0] data_reg;
  logic          op_done_reg;
  logic          load;
  logic          word_step;

  logic [AW-1:0] addr_q [2];
  logic [AW-1:0] src_q, dst_q;

  assign start     = op_start & ~op_start_q_reg;
  assign load      = (state_reg == ST_IDLE) && start;
  assign word_step = (state_reg == ST_WR);

  // Index 0 is the source pointer, index 1 the destination pointer
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_addr
      dmac_addr_cnt #(.AW(AW)) u_addr_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val ((gi == 0) ? src_addr : dst_addr),
        .step     (word_step),
        .inc      ((gi == 0) ? src_inc : dst_inc),
        .q        (addr_q[gi])
      );
    end
  endgenerate

  assign src_q = addr_q[0];
  assign dst_q = addr_q[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      op_start_q_reg <= 1'b0;
      cnt_reg        <= '0;
      data_reg       <= '0;
      op_done_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_start_q_reg <= op_start;
      if (load) begin
        cnt_reg <= data_size;
      end else if (word_step) begin
        cnt_reg <= cnt_reg - LW'(1);
      end
      if (state_reg == ST_LATCH) begin
        data_reg <= m_din;
      end
      // Completion outranks a same-cycle clear so the event is never lost
      if (state_reg == ST_DONE) begin
        op_done_reg <= 1'b1;
      end else if (opdone_clear) begin
        op_done_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    m_req      = 1'b0;
    m_sel      = 1'b0;
    m_wr       = 1'b0;
    m_addr     = '0;
    m_dout     = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (data_size == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        m_req = 1'b1;
        if (m_grant) begin
          state_next = ST_RD;
        end
      end
      ST_RD: begin
        m_req      = 1'b1;
        m_sel      = 1'b1;
        m_addr     = src_q;
        state_next = ST_LATCH;
      end
      ST_LATCH: begin
        m_req      = 1'b1;
        state_next = ST_WR;
      end
      ST_WR: begin
        m_req  = 1'b1;
        m_sel  = 1'b1;
        m_wr   = 1'b1;
        m_addr = dst_q;
        m_dout = data_reg;
        if (cnt_reg == LW'(1)) begin
          state_next = ST_DONE;
        end else if (m_grant) begin
          state_next = ST_RD;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy        = (state_reg != ST_IDLE);
  assign op_done     = op_done_reg;
  assign m_interrupt = op_done_reg & int_en;

endmodule

// File: tb/tb_dmac_master.sv
// Directed bench for dmac_master: a table of block transfers against a bus
// slave model, plus sequences for grant stalls, flag priority and reset.
module tb_dmac_master;
  import dmac_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, op_start, src_inc, dst_inc, int_en, opdone_clear;
  logic [15:0] src_addr, dst_addr;
  logic [7:0]  data_size;
  logic        m_req, m_grant, m_sel, m_wr, busy, op_done, m_interrupt;
  logic [15:0] m_addr;
  logic [31:0] m_dout, m_din;

  dmac_master #(.AW(16), .DW(32), .LW(8)) dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .src_addr(src_addr),
    .dst_addr(dst_addr), .data_size(data_size), .src_inc(src_inc), .dst_inc(dst_inc),
    .int_en(int_en), .opdone_clear(opdone_clear), .m_req(m_req), .m_grant(m_grant),
    .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din),
    .busy(busy), .op_done(op_done), .m_interrupt(m_interrupt)
  );

  always #5 clk = ~clk;

  // Slave: registered read data; ALU result port returns 0xCAFE0000 + index
  logic [31:0] mem [0:65535];
  logic [31:0] rd_data = '0;
  int          res_idx = 0;
  logic        res_clr = 1'b0;
  int          cyc_cnt = 0;
  int          log_n = 0;
  logic        log_wr [256];
  logic [15:0] log_addr [256];
  logic [31:0] log_data [256];
  int          log_cyc [256];

  assign m_din = rd_data;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (res_clr) res_idx <= 0;
    if (m_sel && !m_wr) begin
      if (m_addr == ALU_RESULT) begin
        rd_data <= 32'hCAFE_0000 + 32'(res_idx);
        res_idx <= res_idx + 1;
      end else begin
        rd_data <= {16'hD00D, m_addr};
      end
    end
    if (m_sel && m_wr) mem[m_addr] <= m_dout;
    if (m_sel) begin
      log_wr[log_n]   <= m_wr;
      log_addr[log_n] <= m_addr;
      log_data[log_n] <= m_dout;
      log_cyc[log_n]  <= cyc_cnt + 1;
      log_n           <= log_n + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    opdone_clear = 1'b1;
    res_clr      = 1'b1;
    step();
    opdone_clear = 1'b0;
    res_clr      = 1'b0;
  endtask

  typedef struct {
    logic [15:0] src, dst;
    logic [7:0]  size;
    logic        si, di, ie;
    int          exp_cyc, exp_rd, exp_wr;
    logic        chk_addr;
    logic [15:0] rd_first, rd_last, wr_first, wr_last;
    logic [31:0] dat_first, dat_last;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input int idx, input vec_t v);
    int n, base, nrd, nwr, busy_hits;
    logic [15:0] rdf, rdl, wrf, wrl;
    logic [31:0] df, dl;
    string p;
    p = $sformatf("v%0d_", idx);
    do_clear();
    chk({p, "pre_done"}, {31'b0, op_done}, 32'd0);
    src_addr = v.src; dst_addr = v.dst; data_size = v.size;
    src_inc = v.si; dst_inc = v.di; int_en = v.ie; m_grant = 1'b1;
    base = log_n;
    op_start = 1'b1;
    step();
    n = 1;
    while (!op_done && n < 200) begin
      step();
      n++;
    end
    chk({p, "cycles"}, 32'(n), 32'(v.exp_cyc));
    chk({p, "irq"}, {31'b0, m_interrupt}, {31'b0, v.exp_irq});
    busy_hits = 0;
    repeat (6) begin
      step();
      if (busy) busy_hits++;
    end
    op_start = 1'b0;
    chk({p, "no_retrig"}, 32'(busy_hits), 32'd0);
    nrd = 0; nwr = 0; rdf = '0; rdl = '0; wrf = '0; wrl = '0; df = '0; dl = '0;
    for (int k = base; k < log_n; k++) begin
      if (log_wr[k]) begin
        if (nwr == 0) begin wrf = log_addr[k]; df = log_data[k]; end
        wrl = log_addr[k]; dl = log_data[k]; nwr++;
      end else begin
        if (nrd == 0) rdf = log_addr[k];
        rdl = log_addr[k]; nrd++;
      end
    end
    chk({p, "reads"}, 32'(nrd), 32'(v.exp_rd));
    chk({p, "writes"}, 32'(nwr), 32'(v.exp_wr));
    if (v.chk_addr) begin
      chk({p, "rd_first"}, {16'b0, rdf}, {16'b0, v.rd_first});
      chk({p, "rd_last"}, {16'b0, rdl}, {16'b0, v.rd_last});
      chk({p, "wr_first"}, {16'b0, wrf}, {16'b0, v.wr_first});
      chk({p, "wr_last"}, {16'b0, wrl}, {16'b0, v.wr_last});
      chk({p, "dat_first"}, df, v.dat_first);
      chk({p, "dat_last"}, dl, v.dat_last);
    end
  endtask

  initial begin
    int n, base, start_cyc, nrd, nwr, sel_n, rd1, rd2;
    reset_n = 1'b0; op_start = 1'b0; src_addr = '0; dst_addr = '0; data_size = '0;
    src_inc = 1'b0; dst_inc = 1'b0; int_en = 1'b0; opdone_clear = 1'b0; m_grant = 1'b0;
    @(negedge clk);
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req", {31'b0, m_req}, 32'd0);
    chk("rst_sel", {31'b0, m_sel}, 32'd0);
    chk("rst_addr", {16'b0, m_addr}, 32'd0);
    chk("rst_done", {31'b0, op_done}, 32'd0);

    vecs[0] = '{16'h0100, 16'h0003, 8'd3, 1'b1, 1'b0, 1'b1, 12, 3, 3, 1'b1,
                16'h0100, 16'h0102, 16'h0003, 16'h0003, 32'hD00D_0100, 32'hD00D_0102, 1'b1};
    vecs[1] = '{16'h0004, 16'h0200, 8'd2, 1'b0, 1'b1, 1'b0, 9, 2, 2, 1'b1,
                16'h0004, 16'h0004, 16'h0200, 16'h0201, 32'hCAFE_0000, 32'hCAFE_0001, 1'b0};
    vecs[2] = '{16'h0050, 16'h0060, 8'd0, 1'b1, 1'b1, 1'b1, 2, 0, 0, 1'b0,
                16'h0, 16'h0, 16'h0, 16'h0, 32'h0, 32'h0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0300, 8'd2, 1'b1, 1'b1, 1'b1, 9, 2, 2, 1'b1,
                16'hFFFF, 16'h0000, 16'h0300, 16'h0301, 32'hD00D_FFFF, 32'hD00D_0000, 1'b1};
    vecs[4] = '{16'h0010, 16'h0011, 8'd1, 1'b1, 1'b1, 1'b0, 6, 1, 1, 1'b1,
                16'h0010, 16'h0010, 16'h0011, 16'h0011, 32'hD00D_0010, 32'hD00D_0010, 1'b0};
    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);
    chk("drain_mem200", mem[16'h0200], 32'hCAFE_0000);
    chk("drain_mem201", mem[16'h0201], 32'hCAFE_0001);

    // Grant stall: low at REQ edges 2..6 and again at word-1 WR edge through 13
    do_clear();
    src_addr = 16'h0100; dst_addr = 16'h0400; data_size = 8'd2;
    src_inc = 1'b1; dst_inc = 1'b1; int_en = 1'b0; m_grant = 1'b0;
    base = log_n;
    op_start = 1'b1;
    step();
    start_cyc = cyc_cnt;
    n = 1;
    while (!op_done && n < 60) begin
      m_grant = !(((n + 1) >= 2 && (n + 1) <= 6) || ((n + 1) >= 10 && (n + 1) <= 13));
      step();
      n++;
    end
    op_start = 1'b0; m_grant = 1'b1;
    chk("stall_cycles", 32'(n), 32'd18);
    sel_n = log_n - base; rd1 = 0; rd2 = 0; nrd = 0;
    for (int k = base; k < log_n; k++) begin
      if (!log_wr[k]) begin
        if (nrd == 0) rd1 = log_cyc[k] - start_cyc + 1;
        else rd2 = log_cyc[k] - start_cyc + 1;
        nrd++;
      end
    end
    chk("stall_sel_count", 32'(sel_n), 32'd4);
    chk("stall_rd1_edge", 32'(rd1), 32'd8);
    chk("stall_rd2_edge", 32'(rd2), 32'd15);
    chk("stall_mem400", mem[16'h0400], 32'hD00D_0100);
    chk("stall_mem401", mem[16'h0401], 32'hD00D_0101);

    // Clear coinciding with DONE: completion must win
    do_clear();
    src_addr = 16'h0020; dst_addr = 16'h0021; data_size = 8'd1; int_en = 1'b1;
    op_start = 1'b1;
    repeat (5) step();
    opdone_clear = 1'b1;
    step();
    chk("prio_done", {31'b0, op_done}, 32'd1);
    chk("prio_irq", {31'b0, m_interrupt}, 32'd1);
    opdone_clear = 1'b0;
    op_start = 1'b0;
    step();
    chk("prio_sticky", {31'b0, op_done}, 32'd1);

    // Restart with op_done still set, then reset during LATCH of word 2
    src_addr = 16'h0100; dst_addr = 16'h0500; data_size = 8'd3;
    src_inc = 1'b1; dst_inc = 1'b1;
    base = log_n;
    op_start = 1'b1;
    repeat (6) step();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    chk("mid_done_kept", {31'b0, op_done}, 32'd1);
    reset_n = 1'b0;
    step();
    chk("rr_busy", {31'b0, busy}, 32'd0);
    chk("rr_req", {31'b0, m_req}, 32'd0);
    chk("rr_sel_wr", {30'b0, m_sel, m_wr}, 32'd0);
    chk("rr_addr", {16'b0, m_addr}, 32'd0);
    chk("rr_dout", m_dout, 32'd0);
    chk("rr_done_irq", {30'b0, op_done, m_interrupt}, 32'd0);
    op_start = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (8) step();
    nwr = 0;
    for (int k = base; k < log_n; k++) if (log_wr[k]) nwr++;
    chk("rr_writes", 32'(nwr), 32'd1);
    chk("rr_idle_after", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmac_master.md
Name: dmac_master

Overview:
- Bus initiator (DMA engine) for the shared sel/wr/addr/din/dout bus that the ALU slave and memory sit on.
- Copies a block of 32-bit words from a source address to a destination address. Each word is one bus read followed by one bus write.
- Either address can stay fixed, so the block can stream operands into the ALU instruction/register ports or drain the ALU result port into memory.
- Requests the bus from the arbiter and raises a maskable done interrupt at the end of the block.

Parameters:
- AW, 16, bus address width
- DW, 32, bus data width
- LW, 8, transfer-length width (maximum 2^LW-1 words)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- op_start  in  1  start request; rising edge accepted only when idle
- src_addr  in  AW  source base address, sampled at start
- dst_addr  in  AW  destination base address, sampled at start
- data_size  in  LW  word count, sampled at start
- src_inc  in  1  1 = source address +1 per word; 0 = fixed
- dst_inc  in  1  1 = destination address +1 per word; 0 = fixed
- int_en  in  1  interrupt enable
- opdone_clear  in  1  clears op_done
- m_req  out  1  bus request to arbiter
- m_grant  in  1  bus grant from arbiter
- m_sel  out  1  bus select
- m_wr  out  1  1 = write, 0 = read
- m_addr  out  AW  bus address
- m_dout  out  DW  write data
- m_din  in  DW  read data from slave
- busy  out  1  transfer in progress
- op_done  out  1  sticky completion flag
- m_interrupt  out  1  op_done & int_en

Behaviour:
- Clock, reset, outputs:
  - All state is updated on posedge clk.
  - reset_n=0 at an edge: FSM goes to IDLE; all outputs go to 0; counters, address registers and the data buffer clear.
  - Reset mid-transfer aborts the transfer immediately, with no partial write completion.
- Start detect: a registered copy of op_start; start = op_start & ~op_start_q. Start is ignored unless the FSM is in IDLE.
- States: IDLE, REQ, RD, LATCH, WR, DONE.
- IDLE:
  - On start, load src/dst/size registers.
  - If size==0, go to DONE without any bus activity; otherwise go to REQ.
- REQ: m_req=1. Go to RD on the first edge where m_grant=1.
- RD (one cycle):
  - Drives m_sel=1, m_wr=0, m_addr=src_q.
  - Slave read data is registered, so it is valid in the following cycle.
- LATCH (one cycle):
  - m_sel=0.
  - Capture m_din into the data buffer at the end-of-cycle edge.
- WR (one cycle):
  - Drives m_sel=1, m_wr=1, m_addr=dst_q, m_dout=buffer.
  - At the edge: cnt-1; src_q+src_inc; dst_q+dst_inc.
  - If cnt was 1, go to DONE. Else if m_grant=1, go to RD. Else go to REQ.
- m_req stays 1 from REQ through the final WR.
- Grant is sampled only in REQ and WR. The arbiter must not revoke grant mid-word; the master does not check for it.
- DONE (one cycle): sets op_done, then returns to IDLE.
- busy=1 in every state except IDLE.
- Outside RD and WR: m_sel=0, m_wr=0, m_addr=0, m_dout=0.
- Throughput: 3 cycles per word with continuous grant.
- Latency: with grant already high, from the start edge to op_done=1 is 3N+3 cycles.
- Address wrap: address registers are modulo 2^AW, so 0xFFFF+1 = 0x0000.
- op_done:
  - Sticky until opdone_clear=1.
  - Set and clear in the same cycle: set wins.
  - A new start while op_done=1 is allowed; op_done stays 1 until it is cleared.
- op_start held high across completion does not retrigger; a new rising edge is required.

Decomposition:
- Shared package dmac_pkg holds:
  - state encoding localparams (3-bit)
  - AW/DW/LW defaults
  - ALU slave register offsets used as DMA targets: 0x00 op start, 0x03 instruction, 0x04 result, 0x10-0x1F register file
- One natural sub-module, dmac_addr_cnt: AW-bit loadable register with increment enable, instantiated twice (source and destination). The word counter stays inline.

Test Plan:
- Basic copy, incrementing source, fixed destination:
  - Stimulus: src=0x0100, src_inc=1, dst=0x0003, dst_inc=0, size=3, grant tied 1, memory[0x100..0x102]=A,B,C.
  - Response: bus writes A,B,C to address 0x0003; reads at 0x100, 0x101, 0x102; op_done at cycle 12.
- Result drain, fixed source:
  - Stimulus: src=0x0004, src_inc=0, dst=0x0200, dst_inc=1, size=2, slave returns R0,R1.
  - Response: mem[0x200]=R0, mem[0x201]=R1; exactly two reads of address 0x04.
- Zero length:
  - Stimulus: size=0.
  - Response: m_sel never asserted; op_done=1 two cycles after the start edge; m_interrupt=1 when int_en=1.
- Grant stall:
  - Stimulus: grant low for 5 cycles at start, then dropped after word 1 for 4 cycles, size=2.
  - Response: m_sel=0 throughout both waits; correct data order; op_done delayed by 9 cycles.
- Wrap and start edge:
  - Stimulus: src=0xFFFF, src_inc=1, size=2, op_start held high past completion.
  - Response: reads at 0xFFFF then 0x0000; no second transfer starts.
- Reset and flag priority:
  - Stimulus: reset_n=0 during LATCH of word 2, then opdone_clear asserted in the same cycle as DONE.
  - Response: after reset, all outputs are 0 and no write for word 2 occurs; in the same-cycle case op_done stays 1.
